// File: rtl/cnn_pkg.sv
// Shared dimension and bus-layout helpers for the conv-layer front end.
package cnn_pkg;

    typedef int dim_t;

    function automatic dim_t padded_dim(input dim_t dim, input dim_t pad);
        return dim + 2 * pad;
    endfunction

    function automatic dim_t out_dim(input dim_t dim, input dim_t k, input dim_t pad, input dim_t stride);
        return (dim + 2 * pad - k) / stride + 1;
    endfunction

    function automatic dim_t pixel_bits(input dim_t dw, input dim_t ch_num);
        return dw * ch_num;
    endfunction

    // Bit offset of one channel of one tap inside the flattened window bus.
    function automatic dim_t tap_offset(input dim_t row, input dim_t col, input dim_t ch,
                                        input dim_t k, input dim_t ch_num, input dim_t dw);
        return ((row * k + col) * ch_num + ch) * dw;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Fixed-depth pixel delay line: out_data is the word written pBUFFER_WIDTH enables ago.
module line_buffer #(
    parameter int pDATA_WIDTH   = 8,
    parameter int pBUFFER_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [pDATA_WIDTH-1:0] in_data,
    output logic [pDATA_WIDTH-1:0] out_data
);

    localparam int AW = (pBUFFER_WIDTH > 1) ? $clog2(pBUFFER_WIDTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(pBUFFER_WIDTH - 1);

    logic [pDATA_WIDTH-1:0] mem [pBUFFER_WIDTH];
    logic [AW-1:0]          ptr;

    // Circular buffer: the slot read this cycle is the one overwritten, giving a fixed delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= in_data;
        end
    end

    assign out_data = mem[ptr];

endmodule

// File: rtl/cnn_window_gen.sv
// Sliding-window generator: inserts zero padding, emits KxKxC windows at stride-aligned
// positions with out_last on the final window of each frame.
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int pDATA_WIDTH   = 8,
    parameter int pIN_CHANNEL   = 4,
    parameter int pINPUT_WIDTH  = 640,
    parameter int pINPUT_HEIGHT = 480,
    parameter int pKERNEL_SIZE  = 3,
    parameter int pPADDING      = 1,
    parameter int pSTRIDE       = 1
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      in_valid,
    output logic                                                      in_ready,
    input  logic [pDATA_WIDTH*pIN_CHANNEL-1:0]                        in_data,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [pDATA_WIDTH*pIN_CHANNEL*pKERNEL_SIZE*pKERNEL_SIZE-1:0] out_data,
    output logic                                                      out_last
);

    localparam int K      = pKERNEL_SIZE;
    localparam int P      = pPADDING;
    localparam int S      = pSTRIDE;
    localparam int W      = pINPUT_WIDTH;
    localparam int H      = pINPUT_HEIGHT;
    localparam int PW     = pixel_bits(pDATA_WIDTH, pIN_CHANNEL);
    localparam int WP     = padded_dim(W, P);
    localparam int HP     = padded_dim(H, P);
    localparam int RW     = $clog2(HP);
    localparam int CW     = $clog2(WP);
    localparam int LAST_R = HP - 1 - ((HP - K) % S);
    localparam int LAST_C = WP - 1 - ((WP - K) % S);

    logic [RW-1:0] r;
    logic [CW-1:0] c;
    int            ri;
    int            ci;
    logic          pad_pos;
    logic          complete;
    logic          at_last;
    logic          stall;
    logic          advance;
    logic [PW-1:0] pixel;
    logic [PW-1:0] win    [K][K];
    logic [PW-1:0] lb_out [K-1];

    assign ri = int'(r);
    assign ci = int'(c);

    always_comb begin
        pad_pos  = (ri < P) || (ri >= H + P) || (ci < P) || (ci >= W + P);
        complete = (ri >= K - 1) && (ci >= K - 1) &&
                   (((ri - K + 1) % S) == 0) && (((ci - K + 1) % S) == 0);
        at_last  = (ri == LAST_R) && (ci == LAST_C);
    end

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~pad_pos & ~stall & ~rst;
    assign advance  = ~stall & (pad_pos | in_valid);
    assign pixel    = pad_pos ? '0 : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (advance) begin
            if (c == CW'(WP - 1)) begin
                c <= '0;
                r <= (r == RW'(HP - 1)) ? '0 : r + RW'(1);
            end else begin
                c <= c + CW'(1);
            end
        end
    end

    // Row 0 takes the live pixel; each older row is fed by the line buffer above it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (advance) begin
            win[0][0] <= pixel;
            for (int i = 1; i < K; i++) begin
                win[i][0] <= lb_out[i-1];
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 1; j < K; j++) begin
                    win[i][j] <= win[i][j-1];
                end
            end
        end
    end

    for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
        line_buffer #(
            .pDATA_WIDTH  (PW),
            .pBUFFER_WIDTH(WP - K)
        ) u_line_buffer (
            .clk     (clk),
            .rst     (rst),
            .en      (advance),
            .in_data (win[gi][K-1]),
            .out_data(lb_out[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (advance && complete) begin
            out_valid <= 1'b1;
            out_last  <= at_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    for (genvar gr = 0; gr < K; gr++) begin : g_row
        for (genvar gc = 0; gc < K; gc++) begin : g_col
            assign out_data[tap_offset(gr, gc, 0, K, pIN_CHANNEL, pDATA_WIDTH) +: PW] = win[gr][gc];
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Randomized self-checking bench for cnn_window_gen: three 4x4 instances (S=1, S=2, P=0)
// compared against a window-extraction model built from plain padded-frame arithmetic.
module tb_cnn_window_gen;

    localparam int DW = 8;
    localparam int C  = 4;
    localparam int K  = 3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = DW * C;
    localparam int WB = PW * K * K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [2:0]          in_valid;
    logic [2:0]          out_ready;
    logic [2:0][PW-1:0]  in_data;
    logic                rdy0, rdy1, rdy2;
    logic                ov0, ov1, ov2;
    logic                ol0, ol1, ol2;
    logic [WB-1:0]       od0, od1, od2;

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] pix_q [$];
    logic [WB-1:0] exp_w [$];
    logic          exp_l [$];
    logic [WB-1:0] got_w [$];
    logic          got_l [$];

    logic [WB-1:0] ref_d;
    logic          ref_l;
    logic [WB-1:0] st_d [5];
    logic          st_l [5];
    logic          st_r [5];

    cnn_window_gen #(.pDATA_WIDTH(DW), .pIN_CHANNEL(C), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
                     .pKERNEL_SIZE(K), .pPADDING(1), .pSTRIDE(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy0), .in_data(in_data[0]),
        .out_valid(ov0), .out_ready(out_ready[0]), .out_data(od0), .out_last(ol0));

    cnn_window_gen #(.pDATA_WIDTH(DW), .pIN_CHANNEL(C), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
                     .pKERNEL_SIZE(K), .pPADDING(1), .pSTRIDE(2)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy1), .in_data(in_data[1]),
        .out_valid(ov1), .out_ready(out_ready[1]), .out_data(od1), .out_last(ol1));

    cnn_window_gen #(.pDATA_WIDTH(DW), .pIN_CHANNEL(C), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
                     .pKERNEL_SIZE(K), .pPADDING(0), .pSTRIDE(1)) dut_p0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy2), .in_data(in_data[2]),
        .out_valid(ov2), .out_ready(out_ready[2]), .out_data(od2), .out_last(ol2));

    function automatic logic get_ready(input int s);
        case (s)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_valid(input int s);
        case (s)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_last(input int s);
        case (s)
            0:       return ol0;
            1:       return ol1;
            default: return ol2;
        endcase
    endfunction

    function automatic logic [WB-1:0] get_data(input int s);
        case (s)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

    function automatic logic [7:0] ch0(input logic [WB-1:0] w, input int row, input int col);
        return w[((row * K + col) * C) * DW +: 8];
    endfunction

    // Golden model: each window is cut straight out of the zero-bordered frame.
    function automatic void add_frame_expect(input int p, input int s, input int base);
        int            wp, hp, ho, wo, pr, pc, y, x;
        logic [WB-1:0] w;
        wp = W + 2 * p;
        hp = H + 2 * p;
        ho = (hp - K) / s + 1;
        wo = (wp - K) / s + 1;
        for (int oy = 0; oy < ho; oy++) begin
            for (int ox = 0; ox < wo; ox++) begin
                w  = '0;
                pr = oy * s + K - 1;
                pc = ox * s + K - 1;
                for (int row = 0; row < K; row++) begin
                    for (int col = 0; col < K; col++) begin
                        y = pr - row - p;
                        x = pc - col - p;
                        if (y >= 0 && y < H && x >= 0 && x < W)
                            w[((row * K + col) * C) * DW +: PW] = pix_q[base + y * W + x];
                    end
                end
                exp_w.push_back(w);
                exp_l.push_back(oy == ho - 1 && ox == wo - 1);
            end
        end
    endfunction

    function automatic void clear_all();
        pix_q.delete();
        exp_w.delete();
        exp_l.delete();
        got_w.delete();
        got_l.delete();
    endfunction

    function automatic void push_counting_frame();
        for (int v = 1; v <= 16; v++)
            pix_q.push_back({8'(v + 48), 8'(v + 32), 8'(v + 16), 8'(v)});
    endfunction

    function automatic void push_random_frame();
        for (int v = 0; v < 16; v++)
            pix_q.push_back({2'd3, 6'($urandom()), 2'd2, 6'($urandom()),
                             2'd1, 6'($urandom()), 2'd0, 6'($urandom())});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_stream(input int sel, input int gap_pct, input int stall_at, input int budget,
                              output int cycles, output int gaps, output int pad_low);
        int idx, n, stall_cnt;
        bit iv, ordy, stall_done;
        idx = 0; n = 0; stall_cnt = 0; stall_done = 0;
        gaps = 0; pad_low = 0; cycles = budget;
        while (got_w.size() < exp_w.size() && n < budget) begin
            if (n > 0) @(negedge clk);
            if (stall_at >= 0 && !stall_done && stall_cnt == 0 && get_valid(sel) &&
                got_w.size() == stall_at) begin
                stall_cnt = 5;
                ref_d     = get_data(sel);
                ref_l     = get_last(sel);
            end
            ordy = (stall_cnt == 0);
            iv   = (idx < pix_q.size()) && ($urandom_range(99) >= gap_pct);
            if (idx < pix_q.size() && !iv) gaps++;
            in_valid[sel]  = iv;
            in_data[sel]   = (idx < pix_q.size()) ? pix_q[idx] : PW'($urandom());
            out_ready[sel] = ordy;
            #1;
            if (stall_cnt > 0) begin
                st_d[5 - stall_cnt] = get_data(sel);
                st_l[5 - stall_cnt] = get_last(sel);
                st_r[5 - stall_cnt] = get_ready(sel);
                stall_cnt--;
                if (stall_cnt == 0) stall_done = 1;
            end
            if (n < 36 && !get_ready(sel)) pad_low++;
            if (get_valid(sel) && ordy) begin
                got_w.push_back(get_data(sel));
                got_l.push_back(get_last(sel));
                if (got_w.size() == exp_w.size()) cycles = n + 1;
            end
            if (iv && get_ready(sel)) idx++;
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = '1;
        #1;
        checks++;
        if ({rdy2, rdy1, rdy0} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b want=000", {rdy2, rdy1, rdy0});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ov2, ov1, ov0, ol2, ol1, ol0} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b want=000000", {ov2, ov1, ov0, ol2, ol1, ol0});
        end
        checks++;
        if (od0 !== '0 || od1 !== '0 || od2 !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h want=0", od0 | od1 | od2);
        end
        rst      = 1'b0;
        in_valid = '0;
    endtask

    task automatic test_stride1();
        int cycles, gaps, pad_low, lasts;
        int first_exp [9] = '{6, 5, 0, 2, 1, 0, 0, 0, 0};
        clear_all();
        push_counting_frame();
        add_frame_expect(1, 1, 0);
        do_reset();
        run_stream(0, 0, -1, 200, cycles, gaps, pad_low);
        checks++;
        if (got_w.size() !== 16) begin
            failures++;
            $display("[TB] FAIL s1_count got=%0d want=16", got_w.size());
        end
        lasts = 0;
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            lasts += got_l[i];
            checks++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
                failures++;
                $display("[TB] FAIL s1_window[%0d] got=%h last=%b want=%h last=%b",
                         i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
            end
        end
        if (got_w.size() == 16) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (ch0(got_w[0], k / 3, k % 3) !== 8'(first_exp[k])) begin
                    failures++;
                    $display("[TB] FAIL s1_first_tap[%0d] got=%0d want=%0d",
                             k, ch0(got_w[0], k / 3, k % 3), first_exp[k]);
                end
            end
            checks++;
            if (got_l[15] !== 1'b1 || lasts !== 1 || ch0(got_w[15], 1, 1) !== 8'd16) begin
                failures++;
                $display("[TB] FAIL s1_last got_last=%b count=%0d centre=%0d want 1,1,16",
                         got_l[15], lasts, ch0(got_w[15], 1, 1));
            end
        end
        checks++;
        if (pad_low !== 20) begin
            failures++;
            $display("[TB] FAIL s1_pad_cycles got=%0d want=20", pad_low);
        end
        checks++;
        if (cycles !== 37) begin
            failures++;
            $display("[TB] FAIL s1_cycles got=%0d want=37", cycles);
        end
    endtask

    task automatic test_stride2();
        int cycles, gaps, pad_low;
        int centres [4] = '{1, 3, 9, 11};
        clear_all();
        push_counting_frame();
        add_frame_expect(1, 2, 0);
        do_reset();
        run_stream(1, 0, -1, 200, cycles, gaps, pad_low);
        checks++;
        if (got_w.size() !== 4) begin
            failures++;
            $display("[TB] FAIL s2_count got=%0d want=4", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i] ||
                ch0(got_w[i], 1, 1) !== 8'(centres[i]) || got_l[i] !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL s2_window[%0d] got=%h centre=%0d last=%b want=%h centre=%0d last=%b",
                         i, got_w[i], ch0(got_w[i], 1, 1), got_l[i], exp_w[i], centres[i], (i == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        int cycles, gaps, pad_low;
        clear_all();
        push_counting_frame();
        add_frame_expect(1, 1, 0);
        do_reset();
        run_stream(0, 0, 3, 200, cycles, gaps, pad_low);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (st_d[k] !== ref_d || st_l[k] !== ref_l || st_r[k] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d] data=%h last=%b in_ready=%b want data=%h last=%b in_ready=0",
                         k, st_d[k], st_l[k], st_r[k], ref_d, ref_l);
            end
        end
        checks++;
        if (got_w.size() !== 16 || cycles !== 42) begin
            failures++;
            $display("[TB] FAIL bp_count got=%0d cycles=%0d want=16 cycles=42", got_w.size(), cycles);
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
                failures++;
                $display("[TB] FAIL bp_window[%0d] got=%h last=%b want=%h last=%b",
                         i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random_gaps();
        int cycles, gaps, pad_low;
        clear_all();
        push_random_frame();
        push_random_frame();
        add_frame_expect(1, 1, 0);
        add_frame_expect(1, 1, 16);
        do_reset();
        run_stream(0, 50, -1, 400, cycles, gaps, pad_low);
        checks++;
        if (got_w.size() !== 32) begin
            failures++;
            $display("[TB] FAIL gap_count got=%0d want=32", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
                failures++;
                $display("[TB] FAIL gap_window[%0d] got=%h last=%b want=%h last=%b",
                         i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
            end
        end
        checks++;
        if (cycles > 73 + gaps) begin
            failures++;
            $display("[TB] FAIL gap_throughput got=%0d want<=%0d", cycles, 73 + gaps);
        end
    endtask

    task automatic test_midframe_reset();
        int idx, n, cycles, gaps, pad_low;
        clear_all();
        push_counting_frame();
        add_frame_expect(1, 1, 0);
        do_reset();
        idx = 0;
        n   = 0;
        while (idx < 7 && n < 40) begin
            if (n > 0) @(negedge clk);
            in_valid[0]  = 1'b1;
            in_data[0]   = pix_q[idx];
            out_ready[0] = 1'b1;
            #1;
            if (rdy0) idx++;
            n++;
        end
        @(negedge clk);
        rst         = 1'b1;
        in_valid[0] = 1'b0;
        #1;
        checks++;
        if (rdy0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_rst_ready got=%b want=0", rdy0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b0 || ol0 !== 1'b0 || od0 !== '0) begin
            failures++;
            $display("[TB] FAIL mid_rst_clear valid=%b last=%b data=%h want 0,0,0", ov0, ol0, od0);
        end
        run_stream(0, 0, -1, 200, cycles, gaps, pad_low);
        checks++;
        if (got_w.size() !== 16) begin
            failures++;
            $display("[TB] FAIL mid_count got=%0d want=16", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
                failures++;
                $display("[TB] FAIL mid_window[%0d] got=%h last=%b want=%h last=%b",
                         i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cycles, gaps, pad_low;
        int second_exp [9] = '{11, 10, 9, 7, 6, 5, 3, 2, 1};
        clear_all();
        push_counting_frame();
        push_counting_frame();
        add_frame_expect(0, 1, 0);
        add_frame_expect(0, 1, 16);
        do_reset();
        run_stream(2, 0, -1, 200, cycles, gaps, pad_low);
        checks++;
        if (got_w.size() !== 8 || cycles !== 33) begin
            failures++;
            $display("[TB] FAIL b2b_count got=%0d cycles=%0d want=8 cycles=33", got_w.size(), cycles);
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
                failures++;
                $display("[TB] FAIL b2b_window[%0d] got=%h last=%b want=%h last=%b",
                         i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
            end
        end
        if (got_w.size() > 4) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (ch0(got_w[4], k / 3, k % 3) !== 8'(second_exp[k])) begin
                    failures++;
                    $display("[TB] FAIL b2b_second_tap[%0d] got=%0d want=%0d",
                             k, ch0(got_w[4], k / 3, k % 3), second_exp[k]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        test_reset();
        test_stride1();
        test_stride2();
        test_backpressure();
        test_random_gaps();
        test_midframe_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Next-generation sliding-window generator for the conv layers. Takes a raster-order multi-channel pixel stream with a valid/ready handshake.
- Inserts zero padding internally; the upstream sends only real pixels.
- Emits K x K x C receptive fields only at stride-aligned output positions, with out_last on the final window of each frame.
- Sits between the feature-map source and the conv PE array; replaces fixed-stride, externally-padded buffering.

Parameters:
- pDATA_WIDTH, 8, bits per channel sample
- pIN_CHANNEL, 4, channels packed per pixel
- pINPUT_WIDTH, 640, real pixels per row (W)
- pINPUT_HEIGHT, 480, real rows per frame (H)
- pKERNEL_SIZE, 3, window size K (>=2)
- pPADDING, 1, zero border P on every side (0..K-1)
- pSTRIDE, 1, window stride S (1..K)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  DW*C  one pixel; channel c at [c*DW +: DW]
- out_valid  out  1  out_data holds a complete window
- out_ready  in  1  downstream accepts window
- out_data  out  DW*C*K*K  tap (row,col) channel c at [((row*K+col)*C+c)*DW +: DW]; row 0 = newest row, col 0 = newest column
- out_last  out  1  qualifies out_valid; last window of frame

Behaviour:
- Padded frame: Wp = W+2P, Hp = H+2P. Position counters (r,c) scan Wp x Hp in raster order. pad_pos = r<P or r>=H+P or c<P or c>=W+P.
- stall = out_valid & ~out_ready.
- in_ready = ~pad_pos & ~stall & ~rst.
- advance = ~stall & (pad_pos | in_valid).
- On advance:
  - Shift in in_data, or all-zero if pad_pos, through the window registers and K-1 line buffers.
  - Line buffer depth is Wp-K, each DW*C wide.
  - Increment c; on c=Wp-1, wrap c to 0 and increment r; on (r,c)=(Hp-1,Wp-1), wrap both to 0. The next frame starts immediately.
- Window complete on an advance when:
  - r>=K-1 and c>=K-1,
  - (r-K+1) mod S = 0, and
  - (c-K+1) mod S = 0.
- out_valid:
  - Set the cycle after a completing advance (latency 1 from the accepting in_ready&in_valid, or from the pad cycle).
  - Cleared after out_ready handshake unless another completing advance occurs in the same cycle; then it stays 1 with new data.
- out_last: registered alongside out_valid; 1 when the completing position is (Hp-1-((Hp-K) mod S), Wp-1-((Wp-K) mod S)).
- out_data is driven straight from the window registers. It is stable while stall holds.
- Windows per frame: Ho*Wo, where Ho = (Hp-K)/S+1 and Wo = (Wp-K)/S+1.
- Pad positions consume one cycle each with no input handshake. Pad zeros are indistinguishable from data zeros.
- Reset (any time, including mid-frame):
  - r, c, window registers = 0; out_valid = 0; out_last = 0.
  - Line buffer contents are don't-care: a window completes only after K-1 full rows have been rewritten.
- in_valid gaps while not at a pad position: no advance, state holds.
- Widths: counters $clog2(Hp), $clog2(Wp); no arithmetic on data.

Decomposition:
- Shared package cnn_pkg:
  - function padded_dim(dim, P)
  - function out_dim(dim, K, P, S)
  - function tap_offset(row, col, ch, C, DW)
  - typedef for pixel bus width helper
- Sub-module: existing line_buffer, instantiated with pDATA_WIDTH = DW*C and pBUFFER_WIDTH = Wp-K.
- Position counter and window-valid logic live in the top module.

Test Plan:
- W=H=4, K=3, P=1, S=1, C=1; pixels 1..16 with in_valid stuck 1, out_ready=1:
  - 16 windows.
  - First window rows (newest->oldest) = {6,5,0},{2,1,0},{0,0,0} with col 0 newest.
  - out_last only on the 16th window, centre 16.
  - in_ready low on exactly 20 pad cycles per frame.
- Same config with S=2: exactly 4 windows, centres 1,3,9,11; out_last on centre 11.
- Backpressure: drop out_ready for 5 cycles while out_valid=1:
  - out_data and out_last are unchanged.
  - in_ready=0 and r,c frozen.
  - Release gives exactly one handshake per window; no loss or duplication.
- Random in_valid gaps (50%), C=4, distinct channel values: window contents and channel ordering match a golden model; throughput drops only on gaps and stalls.
- Assert rst for 1 cycle mid-frame (after pixel 7):
  - Next cycle out_valid=0, out_last=0, out_data=0.
  - Resending a full frame 1..16 reproduces test 1 exactly.
- Back-to-back frames, P=0, K=3, W=H=4: 4 windows per frame. The second frame's first window = {11,10,9},{7,6,5},{3,2,1} (newest row first, col 0 newest).
